hub75_scan_sequencer: RTL and testbench

- Timing master for the HUB75 display datapath, replacing ad-hoc sequencing in the controller top level.
- Walks the read side of the double-buffered framebuffer column by column, row by row and bit-plane by bit-plane.
- Drives the panel's hub75_clk, hub75_latch, hub75_oe and hub75_addr with binary-coded-modulation on-times.
- Owns the buffer-swap handshake with the SPI write side, so swaps only happen at frame boundaries.

---
 rtl/hub75_scan_sequencer.sv | 162 ++++++++++++++++
 tb/tb_hub75_scan_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_sequencer.sv
// HUB75 scan timing master: walks the read-side framebuffer column/row/bit-plane,
// drives panel clk/latch/oe/addr with binary-coded-modulation on-times, and swaps buffers at frame ends.
module hub75_scan_sequencer #(
   parameter int COLUMNS      = 64,
   parameter int ROW_BITS     = 4,
   parameter int BITS_PER_RGB = 2,
   parameter int OE_BASE      = 4
) (
   input  logic                                                   clk,
   input  logic                                                   n_reset,
   input  logic                                                   enable,
   input  logic                                                   swap_req,
   output logic [$clog2(COLUMNS)-1:0]                             rd_col,
   output logic [ROW_BITS-1:0]                                    rd_row,
   output logic [((BITS_PER_RGB > 1) ? $clog2(BITS_PER_RGB) : 1)-1:0] rd_plane,
   output logic                                                   read_buffer,
   output logic                                                   swap_ack,
   output logic                                                   frame_done,
   output logic                                                   hub75_clk,
   output logic                                                   hub75_latch,
   output logic                                                   hub75_oe,
   output logic [ROW_BITS-1:0]                                    hub75_addr
);

   localparam int COL_W     = $clog2(COLUMNS);
   localparam int PLANE_W   = (BITS_PER_RGB > 1) ? $clog2(BITS_PER_RGB) : 1;
   localparam int SHIFT_LEN = 2 * COLUMNS + 1;
   localparam int OE_MAX    = OE_BASE << (BITS_PER_RGB - 1);
   localparam int CNT_MAX   = (SHIFT_LEN > OE_MAX) ? SHIFT_LEN : OE_MAX;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]    SHIFT_LAST = CNT_W'(2 * COLUMNS);
   localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(BITS_PER_RGB - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_BLANK,
      S_LATCH,
      S_DISPLAY
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [COL_W-1:0]     rd_col_q, rd_col_d;
   logic [ROW_BITS-1:0]  rd_row_q, rd_row_d;
   logic [PLANE_W-1:0]   rd_plane_q, rd_plane_d;
   logic                 read_buffer_q, read_buffer_d;
   logic                 frame_done_q, frame_done_d;
   logic                 hub75_clk_q, hub75_clk_d;
   logic                 hub75_latch_q, hub75_latch_d;
   logic                 hub75_oe_q, hub75_oe_d;
   logic [ROW_BITS-1:0]  hub75_addr_q, hub75_addr_d;
   logic [CNT_W-1:0]     disp_last;

   // Plane p stays lit for OE_BASE << p cycles.
   assign disp_last = (CNT_W'(OE_BASE) << rd_plane_q) - CNT_W'(1);

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      rd_col_d      = rd_col_q;
      rd_row_d      = rd_row_q;
      rd_plane_d    = rd_plane_q;
      read_buffer_d = read_buffer_q;
      hub75_addr_d  = hub75_addr_q;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
            end
         end
         S_SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               state_d      = S_BLANK;
               cnt_d        = '0;
               hub75_addr_d = rd_row_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_BLANK: state_d = S_LATCH;
         S_LATCH: begin
            state_d = S_DISPLAY;
            cnt_d   = '0;
         end
         S_DISPLAY: begin
            if (cnt_q == disp_last) begin
               cnt_d   = '0;
               state_d = enable ? S_SHIFT : S_IDLE;
               if (rd_plane_q == PLANE_LAST) begin
                  rd_plane_d = '0;
                  rd_row_d   = rd_row_q + ROW_BITS'(1);
               end else begin
                  rd_plane_d = rd_plane_q + PLANE_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are derived from the next state so each register shows the phase it belongs to.
      if (state_d == S_SHIFT && cnt_d < SHIFT_LAST && !cnt_d[0])
         rd_col_d = cnt_d[COL_W:1];
      hub75_clk_d   = (state_d == S_SHIFT) && !cnt_d[0] && (cnt_d != '0);
      hub75_latch_d = (state_d == S_LATCH);
      hub75_oe_d    = (state_d != S_DISPLAY);
      frame_done_d  = (state_d == S_DISPLAY) && (cnt_d == disp_last) &&
                      (rd_row_q == ROW_LAST) && (rd_plane_q == PLANE_LAST);

      if (frame_done_q && swap_req)
         read_buffer_d = !read_buffer_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         rd_col_q      <= '0;
         rd_row_q      <= '0;
         rd_plane_q    <= '0;
         read_buffer_q <= 1'b0;
         frame_done_q  <= 1'b0;
         hub75_clk_q   <= 1'b0;
         hub75_latch_q <= 1'b0;
         hub75_oe_q    <= 1'b1;
         hub75_addr_q  <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rd_col_q      <= rd_col_d;
         rd_row_q      <= rd_row_d;
         rd_plane_q    <= rd_plane_d;
         read_buffer_q <= read_buffer_d;
         frame_done_q  <= frame_done_d;
         hub75_clk_q   <= hub75_clk_d;
         hub75_latch_q <= hub75_latch_d;
         hub75_oe_q    <= hub75_oe_d;
         hub75_addr_q  <= hub75_addr_d;
      end
   end

   assign rd_col      = rd_col_q;
   assign rd_row      = rd_row_q;
   assign rd_plane    = rd_plane_q;
   assign read_buffer = read_buffer_q;
   assign frame_done  = frame_done_q;
   assign hub75_clk   = hub75_clk_q;
   assign hub75_latch = hub75_latch_q;
   assign hub75_oe    = hub75_oe_q;
   assign hub75_addr  = hub75_addr_q;
   // The ack reflects swap_req in the frame_done cycle itself, matching the edge that toggles read_buffer.
   assign swap_ack    = frame_done_q & swap_req;

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// Directed bench for hub75_scan_sequencer: scoreboarded latch addresses and OE-low
// run lengths, frame timing, swap handshake, enable gating, async reset, protocol rules.
module tb_hub75_scan_sequencer;

   localparam int COLS      = 64;
   localparam int ROWS      = 16;
   localparam int PLANES    = 2;
   localparam int OE_B      = 4;
   localparam int FRAME_LEN = ROWS * (PLANES * (2 * COLS + 3) + OE_B * ((1 << PLANES) - 1));

   logic       clk;
   logic       n_reset;
   logic       enable;
   logic       swap_req;
   logic [5:0] rd_col;
   logic [3:0] rd_row;
   logic [0:0] rd_plane;
   logic       read_buffer;
   logic       swap_ack;
   logic       frame_done;
   logic       hub75_clk;
   logic       hub75_latch;
   logic       hub75_oe;
   logic [3:0] hub75_addr;

   hub75_scan_sequencer #(
      .COLUMNS(COLS), .ROW_BITS(4), .BITS_PER_RGB(PLANES), .OE_BASE(OE_B)
   ) dut (
      .clk(clk), .n_reset(n_reset), .enable(enable), .swap_req(swap_req),
      .rd_col(rd_col), .rd_row(rd_row), .rd_plane(rd_plane),
      .read_buffer(read_buffer), .swap_ack(swap_ack), .frame_done(frame_done),
      .hub75_clk(hub75_clk), .hub75_latch(hub75_latch), .hub75_oe(hub75_oe),
      .hub75_addr(hub75_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int clk_edges = 0;
   int prot_err = 0;
   int oe_run = 0;
   int fd_count = 0;
   int fd_last_cyc = 0;
   int fd_prev_cyc = 0;
   int ack_count = 0;
   logic [3:0] last_latch_addr = '0;
   logic prev_clk = 1'b0;
   logic prev_oe = 1'b1;
   logic [3:0] prev_addr = '0;
   int exp_addr_q[$];
   int exp_oe_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic resync();
      prev_clk  = hub75_clk;
      prev_oe   = hub75_oe;
      prev_addr = hub75_addr;
      oe_run    = 0;
   endtask

   // One cycle: sample at the falling edge, run protocol rules and scoreboard pops.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (hub75_clk && !prev_clk) clk_edges++;
      if (hub75_latch && !hub75_oe) prot_err++;
      if (hub75_clk && (!hub75_oe || hub75_latch)) prot_err++;
      if (hub75_addr != prev_addr && !(hub75_oe && prev_oe)) prot_err++;
      if (!hub75_oe) begin
         oe_run++;
      end else if (!prev_oe) begin
         if (exp_oe_q.size() > 0) check("sb_oe_run", oe_run, exp_oe_q.pop_front());
         oe_run = 0;
      end
      if (hub75_latch) begin
         last_latch_addr = hub75_addr;
         if (exp_addr_q.size() > 0) check("sb_latch_addr", hub75_addr, exp_addr_q.pop_front());
      end
      if (frame_done) begin
         fd_count++;
         fd_prev_cyc = fd_last_cyc;
         fd_last_cyc = cyc;
      end
      if (swap_ack) ack_count++;
      prev_clk  = hub75_clk;
      prev_oe   = hub75_oe;
      prev_addr = hub75_addr;
   endtask

   initial begin
      int c0, e0, f0, a0, errs, low;
      bit found;

      // 1. reset, first row-plane
      n_reset = 1'b0; enable = 1'b0; swap_req = 1'b0;
      step(); step();
      check("rst_oe", hub75_oe, 1);
      check("rst_clk", hub75_clk, 0);
      check("rst_latch", hub75_latch, 0);
      check("rst_addr", hub75_addr, 0);
      check("rst_rd_col", rd_col, 0);
      check("rst_read_buffer", read_buffer, 0);
      check("rst_frame_done", frame_done, 0);

      for (int f = 0; f < 2; f++)
         for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < PLANES; p++) begin
               exp_addr_q.push_back(r);
               exp_oe_q.push_back(OE_B << p);
            end

      n_reset = 1'b1; enable = 1'b1;
      c0 = cyc; e0 = clk_edges; errs = 0;
      for (int k = 0; k <= 2 * COLS; k++) begin
         step();
         if (k % 2 == 0 && k < 2 * COLS && rd_col != 6'(k / 2)) errs++;
         if (hub75_clk !== ((k % 2 == 0) && k >= 2)) errs++;
         if (hub75_oe !== 1'b1) errs++;
      end
      check("shift_pattern_errs", errs, 0);
      check("shift_clk_edges", clk_edges - e0, COLS);
      step();
      check("blank_oe", hub75_oe, 1);
      check("blank_latch", hub75_latch, 0);
      step();
      check("latch_pulse", hub75_latch, 1);
      check("latch_addr", hub75_addr, 0);
      low = 0;
      for (int i = 0; i < OE_B; i++) begin
         step();
         if (!hub75_oe) low++;
      end
      check("plane0_oe_low", low, OE_B);
      step();
      check("plane1_shift_oe", hub75_oe, 1);
      check("plane1_rd_plane", rd_plane, 1);

      // 2. two full frames
      for (int i = 0; i < 3 * FRAME_LEN && fd_count < 2; i++) step();
      check("frames_seen", fd_count, 2);
      check("frame1_len", fd_prev_cyc - c0, FRAME_LEN);
      check("frame2_len", fd_last_cyc - fd_prev_cyc, FRAME_LEN);
      step();
      check("sb_addr_drained", exp_addr_q.size(), 0);
      check("sb_oe_drained", exp_oe_q.size(), 0);

      // 3. swap held pending until frame end
      errs = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (read_buffer !== 1'b0) errs++;
      end
      swap_req = 1'b1;
      a0 = ack_count; found = 0;
      for (int i = 0; i < 2 * FRAME_LEN && !found; i++) begin
         step();
         if (frame_done) found = 1;
         else if (read_buffer !== 1'b0 || swap_ack !== 1'b0) errs++;
      end
      check("swap_fd_seen", found, 1);
      check("swap_ack_at_fd", swap_ack, 1);
      check("rb_before_edge", read_buffer, 0);
      step();
      check("rb_after_swap", read_buffer, 1);
      check("swap_ack_dropped", swap_ack, 0);
      check("swap_ack_pulses", ack_count - a0, 1);
      swap_req = 1'b0;
      found = 0;
      for (int i = 0; i < 2 * FRAME_LEN && !found; i++) begin
         step();
         if (frame_done) found = 1;
         if (read_buffer !== 1'b1) errs++;
      end
      check("noswap_fd_seen", found, 1);
      check("noswap_ack_count", ack_count - a0, 1);
      check("read_buffer_stability_errs", errs, 0);

      // 4. enable dropped during row 5 SHIFT
      for (int i = 0; i < FRAME_LEN && !(rd_row == 4'd5 && rd_plane == 1'b0); i++) step();
      check("reach_row5", rd_row, 5);
      for (int i = 0; i < 10; i++) step();
      enable = 1'b0;
      for (int i = 0; i < 300 && hub75_oe; i++) step();
      check("dis_latch_addr", last_latch_addr, 5);
      low = 0;
      for (int i = 0; i < 100 && !hub75_oe; i++) begin
         low++;
         step();
      end
      check("dis_oe_low", low, OE_B);
      e0 = clk_edges; errs = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!hub75_oe || hub75_clk || hub75_latch) errs++;
      end
      check("idle_quiet_errs", errs, 0);
      check("idle_clk_edges", clk_edges - e0, 0);
      check("idle_rd_row", rd_row, 5);
      check("idle_rd_plane", rd_plane, 1);
      enable = 1'b1;
      step();
      check("resume_rd_col", rd_col, 0);
      check("resume_rd_plane", rd_plane, 1);
      for (int i = 0; i < 300 && !hub75_latch; i++) step();
      check("resume_latch_addr", hub75_addr, 5);
      for (int i = 0; i < 10 && hub75_oe; i++) step();
      low = 0;
      for (int i = 0; i < 100 && !hub75_oe; i++) begin
         low++;
         step();
      end
      check("resume_oe_low", low, OE_B << 1);

      // 5. async reset in DISPLAY
      for (int i = 0; i < 300 && hub75_oe; i++) step();
      check("in_display", hub75_oe, 0);
      #2 n_reset = 1'b0;
      #1;
      check("arst_oe", hub75_oe, 1);
      check("arst_clk", hub75_clk, 0);
      check("arst_latch", hub75_latch, 0);
      check("arst_addr", hub75_addr, 0);
      check("arst_rd_col", rd_col, 0);
      check("arst_rd_row", rd_row, 0);
      check("arst_rd_plane", rd_plane, 0);
      check("arst_read_buffer", read_buffer, 0);
      check("arst_swap_ack", swap_ack, 0);
      check("arst_frame_done", frame_done, 0);
      resync();
      step(); step();
      check("arst_hold_oe", hub75_oe, 1);
      n_reset = 1'b1;
      c0 = cyc; e0 = clk_edges; f0 = fd_count;
      step();
      check("restart_rd_row", rd_row, 0);
      check("restart_rd_plane", rd_plane, 0);
      check("restart_rd_col", rd_col, 0);

      // 6. three frames under the protocol monitor
      for (int i = 0; i < 4 * FRAME_LEN && fd_count - f0 < 3; i++) step();
      check("mon_frames", fd_count - f0, 3);
      check("mon_3frame_len", fd_last_cyc - c0, 3 * FRAME_LEN);
      check("mon_clk_edges", clk_edges - e0, 3 * ROWS * PLANES * COLS);
      check("protocol_errs", prot_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
